// File: rtl/fifo_stream_reader_pkg.sv
// Shared types, sizing and helpers for the FIFO read-side stream master.
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } rd_state_t;

  localparam int SKID_DEPTH = 2;

  // Words already owned by the reader (buffered plus in flight, less the one leaving)
  // must leave room for one more read.
  function automatic logic credit_ok(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return committed < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream, seen from the reader (master) or its peers (slave).
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data,
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_stream_skid.sv
// Two-entry skid buffer: absorbs the word still in flight from the FIFO when the stream stalls.
module fifo_stream_skid
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Single-bit pointers wrap naturally at the depth of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO onto a valid/ready stream, hiding the one-cycle read latency
// and throttling reads with a programmable inter-read gap.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [GAP_W-1:0]        gap,
  fifo_stream_reader_if.master    bus,
  output logic [CNT_W-1:0]        rd_count,
  output logic                    busy
);

  rd_state_t       state;
  rd_state_t       state_next;
  logic [GAP_W-1:0] gcnt;
  logic [GAP_W-1:0] gcnt_next;
  logic            inflight;
  logic [1:0]      occ;
  logic            pop;
  logic            credit;
  logic            rd_en;

  assign pop    = bus.m_valid && bus.m_ready;
  assign credit = credit_ok(occ, inflight, pop);
  assign rd_en  = (state == ISSUE) && en && !bus.fifo_empty && credit && !rst;

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != 2'd0);
  assign busy           = inflight || (occ != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gcnt     <= '0;
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      state    <= state_next;
      gcnt     <= gcnt_next;
      inflight <= rd_en;
      if (pop) begin
        rd_count <= rd_count + CNT_W'(1);
      end
    end
  end

  // The gap is sampled at the read that starts it, so a later change applies from the next read.
  always_comb begin
    state_next = state;
    gcnt_next  = gcnt;
    unique case (state)
      IDLE: begin
        if (en) state_next = ISSUE;
      end
      ISSUE: begin
        if (rd_en && (gap != '0)) begin
          state_next = GAP;
          gcnt_next  = gap;
        end
      end
      GAP: begin
        gcnt_next = gcnt - GAP_W'(1);
        if (gcnt == GAP_W'(1)) state_next = ISSUE;
      end
      default: state_next = IDLE;
    endcase
    if (!en) state_next = IDLE;
  end

  fifo_stream_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (bus.fifo_data),
    .pop       (pop),
    .head      (bus.m_data),
    .occ       (occ)
  );

endmodule
